// File: rtl/fpu_pkg.sv
// Shared definitions for the FP ALU front end: op codes, sequencer states, result flags
// and IEEE-754 single-precision field layout.
package fpu_pkg;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } seq_state_e;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    // Bit positions inside rsp_flags {timeout,nan,inf,zero,denorm}
    localparam int unsigned FLAG_DENORM  = 0;
    localparam int unsigned FLAG_ZERO    = 1;
    localparam int unsigned FLAG_INF     = 2;
    localparam int unsigned FLAG_NAN     = 3;
    localparam int unsigned FLAG_TIMEOUT = 4;

    localparam logic [4:0] FLAGS_TIMEOUT = 5'b1_0000;

    localparam int unsigned EXP_W  = 8;
    localparam int unsigned FRAC_W = 23;

endpackage

// File: rtl/fp_classify.sv
// Combinational classifier for an IEEE-754 single word: {nan,inf,zero,denorm}, at most one set.
module fp_classify
    import fpu_pkg::*;
(
    input  logic [31:0] word_i,
    output logic [3:0]  class_o
);

    logic [EXP_W-1:0]  exp_field;
    logic [FRAC_W-1:0] frac_field;
    logic              exp_all_ones;
    logic              exp_all_zero;
    logic              frac_zero;
    logic              unused_sign;

    assign exp_field    = word_i[FRAC_W +: EXP_W];
    assign frac_field   = word_i[FRAC_W-1:0];
    assign unused_sign  = word_i[31];

    assign exp_all_ones = &exp_field;
    assign exp_all_zero = ~|exp_field;
    assign frac_zero    = ~|frac_field;

    assign class_o = {exp_all_ones & ~frac_zero,
                      exp_all_ones &  frac_zero,
                      exp_all_zero &  frac_zero,
                      exp_all_zero & ~frac_zero};

endmodule

// File: rtl/fpu_op_sequencer.sv
// Issues one FP op at a time to the ALU, waits for done (with a watchdog) and returns the
// classified result on a valid/ready response port.
module fpu_op_sequencer
    import fpu_pkg::*;
#(
    parameter int unsigned TAG_W          = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [1:0]       cmd_op_i,
    input  logic [31:0]      cmd_a_i,
    input  logic [31:0]      cmd_b_i,
    input  logic [TAG_W-1:0] cmd_tag_i,
    output logic             alu_start_o,
    output logic [1:0]       alu_ctrl_o,
    output logic [31:0]      alu_a_o,
    output logic [31:0]      alu_b_o,
    input  logic             alu_done_i,
    input  logic [31:0]      alu_result_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [31:0]      rsp_result_o,
    output logic [TAG_W-1:0] rsp_tag_o,
    output logic [4:0]       rsp_flags_o,
    output logic             busy_o
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);

    seq_state_e        state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [1:0]        alu_ctrl_q, alu_ctrl_d;
    logic [31:0]       alu_a_q, alu_a_d;
    logic [31:0]       alu_b_q, alu_b_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [31:0]       rsp_result_q, rsp_result_d;
    logic [4:0]        rsp_flags_q, rsp_flags_d;
    logic [3:0]        result_class;

    fp_classify u_classify (
        .word_i  (alu_result_i),
        .class_o (result_class)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        alu_ctrl_d   = alu_ctrl_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        tag_d        = tag_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid_i) begin
                    alu_ctrl_d = cmd_op_i;
                    alu_a_d    = cmd_a_i;
                    alu_b_d    = cmd_b_i;
                    tag_d      = cmd_tag_i;
                    state_d    = StIssue;
                end
            end
            StIssue: begin
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                cnt_d = cnt_q + CntW'(1);
                // A done arriving in the last watchdog cycle still wins over the timeout
                if (alu_done_i) begin
                    rsp_result_d = alu_result_i;
                    rsp_flags_d  = {1'b0, result_class};
                    state_d      = StResp;
                end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                    rsp_result_d = QNAN;
                    rsp_flags_d  = FLAGS_TIMEOUT;
                    state_d      = StResp;
                end
            end
            StResp: begin
                if (rsp_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            alu_ctrl_q   <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            tag_q        <= '0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            alu_ctrl_q   <= alu_ctrl_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            tag_q        <= tag_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
        end
    end

    assign cmd_ready_o  = (state_q == StIdle);
    assign alu_start_o  = (state_q == StIssue);
    assign rsp_valid_o  = (state_q == StResp);
    assign busy_o       = (state_q != StIdle);
    assign alu_ctrl_o   = alu_ctrl_q;
    assign alu_a_o      = alu_a_q;
    assign alu_b_o      = alu_b_q;
    assign rsp_result_o = rsp_result_q;
    assign rsp_tag_o    = tag_q;
    assign rsp_flags_o  = rsp_flags_q;

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Directed plus randomized bench for fpu_op_sequencer with a cycle-level ALU stub and a
// transaction-level reference model of the expected response and its timing.
module tb_fpu_op_sequencer;

    localparam int unsigned TAG_W = 4;
    localparam int          TO    = 8;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             cmd_valid_i;
    logic             cmd_ready_o;
    logic [1:0]       cmd_op_i;
    logic [31:0]      cmd_a_i;
    logic [31:0]      cmd_b_i;
    logic [TAG_W-1:0] cmd_tag_i;
    logic             alu_start_o;
    logic [1:0]       alu_ctrl_o;
    logic [31:0]      alu_a_o;
    logic [31:0]      alu_b_o;
    logic             alu_done_i;
    logic [31:0]      alu_result_i;
    logic             rsp_valid_o;
    logic             rsp_ready_i;
    logic [31:0]      rsp_result_o;
    logic [TAG_W-1:0] rsp_tag_o;
    logic [4:0]       rsp_flags_o;
    logic             busy_o;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    fpu_op_sequencer #(
        .TAG_W          (TAG_W),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .cmd_valid_i  (cmd_valid_i),
        .cmd_ready_o  (cmd_ready_o),
        .cmd_op_i     (cmd_op_i),
        .cmd_a_i      (cmd_a_i),
        .cmd_b_i      (cmd_b_i),
        .cmd_tag_i    (cmd_tag_i),
        .alu_start_o  (alu_start_o),
        .alu_ctrl_o   (alu_ctrl_o),
        .alu_a_o      (alu_a_o),
        .alu_b_o      (alu_b_o),
        .alu_done_i   (alu_done_i),
        .alu_result_i (alu_result_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_result_o (rsp_result_o),
        .rsp_tag_o    (rsp_tag_o),
        .rsp_flags_o  (rsp_flags_o),
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Reference classification from the IEEE-754 field values
    function automatic logic [4:0] ref_flags(input logic [31:0] w);
        int unsigned e = (w >> 23) & 32'd255;
        int unsigned f = w % (32'd1 << 23);
        if (e == 255) return (f != 0) ? 5'b01000 : 5'b00100;
        if (e == 0)   return (f != 0) ? 5'b00001 : 5'b00010;
        return 5'b00000;
    endfunction

    // One full transaction. done is raised in WAIT cycle 'delay' (0-based); delay<0 or >=TO
    // means the ALU never answers. 'stall' is the number of RESP cycles with rsp_ready low.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] tag, input int delay, input logic [31:0] res,
                          input int stall, input bit stale);
        logic [31:0] exp_res;
        logic [4:0]  exp_flg;
        int          exp_k;
        int          got;
        bit          answers;
        answers = (delay >= 0) && (delay < TO);
        exp_res = answers ? res : 32'h7FC0_0000;
        exp_flg = answers ? ref_flags(res) : 5'b10000;
        exp_k   = answers ? delay : TO - 1;

        check("idle_cmd_ready", 32'(cmd_ready_o), 32'd1);
        check("idle_busy", 32'(busy_o), 32'd0);
        rsp_ready_i = (stall == 0);
        cmd_valid_i = 1'b1;
        cmd_op_i = op; cmd_a_i = a; cmd_b_i = b; cmd_tag_i = tag;
        alu_done_i = stale; alu_result_i = $urandom;
        step();
        // ISSUE
        cmd_valid_i = 1'b0;
        cmd_op_i = 2'($urandom); cmd_a_i = $urandom; cmd_b_i = $urandom;
        cmd_tag_i = 4'($urandom);
        check("issue_start", 32'(alu_start_o), 32'd1);
        check("issue_ctrl", 32'(alu_ctrl_o), 32'(op));
        check("issue_a", alu_a_o, a);
        check("issue_b", alu_b_o, b);
        check("issue_cmd_ready", 32'(cmd_ready_o), 32'd0);
        alu_done_i = stale; alu_result_i = $urandom;
        step();
        // WAIT
        check("wait_start_low", 32'(alu_start_o), 32'd0);
        got = -1;
        for (int k = 0; k < TO + 2; k++) begin
            alu_done_i   = (k == delay);
            alu_result_i = (k == delay) ? res : $urandom;
            step();
            if (rsp_valid_o) begin
                got = k;
                break;
            end
            if (busy_o !== 1'b1 || cmd_ready_o !== 1'b0 || alu_start_o !== 1'b0)
                check("wait_status", {busy_o, cmd_ready_o, alu_start_o}, 32'b100);
        end
        alu_done_i = 1'b0;
        check("wait_cycles", 32'(got), 32'(exp_k));
        for (int s = 0; s <= stall; s++) begin
            if (s == stall) rsp_ready_i = 1'b1;
            check("rsp_valid", 32'(rsp_valid_o), 32'd1);
            check("rsp_result", rsp_result_o, exp_res);
            check("rsp_tag", 32'(rsp_tag_o), 32'(tag));
            check("rsp_flags", 32'(rsp_flags_o), 32'(exp_flg));
            check("rsp_hold_a", alu_a_o, a);
            if (cmd_ready_o !== 1'b0 || busy_o !== 1'b1 || alu_start_o !== 1'b0)
                check("rsp_status", {cmd_ready_o, busy_o, alu_start_o}, 32'b010);
            step();
        end
        rsp_ready_i = 1'b0;
        check("post_rsp_valid", 32'(rsp_valid_o), 32'd0);
        check("post_cmd_ready", 32'(cmd_ready_o), 32'd1);
    endtask

    initial begin
        int c0;
        rst_i = 1'b1; cmd_valid_i = 1'b0; cmd_op_i = '0; cmd_a_i = '0; cmd_b_i = '0;
        cmd_tag_i = '0; alu_done_i = 1'b0; alu_result_i = '0; rsp_ready_i = 1'b0;
        step();
        step();
        check("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
        check("rst_start", 32'(alu_start_o), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_data", {alu_a_o | alu_b_o | rsp_result_o}, 32'd0);
        check("rst_small", {rsp_flags_o, rsp_tag_o, alu_ctrl_o}, 32'd0);
        rst_i = 1'b0;
        step();

        // Add 1.0 + 2.0 = 3.0
        run_op(2'd0, 32'h3F80_0000, 32'h4000_0000, 4'd5, 2, 32'h4040_0000, 0, 1'b0);

        // Back-to-back mul then div with a zero-wait ALU and consumer
        c0 = cyc;
        run_op(2'd2, 32'h4000_0000, 32'h4040_0000, 4'd1, 0, 32'h40C0_0000, 0, 1'b0);
        check("throughput", 32'(cyc - c0), 32'd4);
        run_op(2'd3, 32'h3F80_0000, 32'h0000_0000, 4'd2, 0, 32'h7F80_0000, 0, 1'b0);

        // Timeout, then done coinciding with the last watchdog cycle
        run_op(2'd1, 32'h1234_5678, 32'h9ABC_DEF0, 4'd7, -1, 32'h0, 0, 1'b0);
        run_op(2'd1, 32'h0000_0001, 32'h8000_0000, 4'd9, TO - 1, 32'h3F00_0000, 0, 1'b0);

        // Backpressure on the response, with a stale done during issue
        run_op(2'd2, 32'hC000_0000, 32'h0000_0003, 4'd12, 3, 32'h0000_0003, 5, 1'b1);

        // Reset in the middle of WAIT, followed by a late done
        cmd_valid_i = 1'b1; cmd_op_i = 2'd3; cmd_a_i = 32'h4100_0000;
        cmd_b_i = 32'h4000_0000; cmd_tag_i = 4'd11;
        step();
        cmd_valid_i = 1'b0;
        step();
        step();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        check("midrst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        check("midrst_cmd_ready", 32'(cmd_ready_o), 32'd1);
        check("midrst_busy", 32'(busy_o), 32'd0);
        check("midrst_data", {alu_a_o | alu_b_o | rsp_result_o}, 32'd0);
        alu_done_i = 1'b1; alu_result_i = 32'h4080_0000;
        step();
        alu_done_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("late_done_ignored", {rsp_valid_o, busy_o}, 32'd0);
            step();
        end

        // Randomized transactions against the reference model
        for (int n = 0; n < 40; n++) begin
            logic [31:0] r;
            logic [7:0]  e;
            logic [22:0] f;
            case ($urandom_range(0, 3))
                0:       e = 8'h00;
                1:       e = 8'hFF;
                default: e = 8'($urandom);
            endcase
            f = ($urandom_range(0, 2) == 0) ? 23'd0 : 23'($urandom);
            r = {1'($urandom), e, f};
            run_op(2'($urandom), $urandom, $urandom, 4'($urandom),
                   $urandom_range(0, TO + 1), r, $urandom_range(0, 3),
                   1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
